i2c_slave_regfile: RTL and testbench
====================================

I2C_SLAVE_REGFILE -- requirements
Module: i2c_slave_regfile

Interface
REQ-001 Parameters SHALL be:
- REG_DEPTH, default 16: number of 8-bit registers; allowed range 2..256.
- FILTER_LEN, default 3: SCL/SDA glitch-filter length in clk cycles; allowed range 1..15.
- STRETCH_EN, default 1: 1 enables SCL clock stretching.
REQ-002 Ports SHALL be, clock and reset first (name, direction, width, meaning):
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- sda  inout  1  I2C data; open-drain, drives 0 or Z only.
- scl  inout  1  I2C clock; open-drain, drives 0 or Z only.
- address  in  7  own slave address.
- hst_we  in  1  host write enable.
- hst_addr  in  $clog2(REG_DEPTH)  host register index.
- hst_wdata  in  8  host write data.
- hst_rdata  out  8  registered read data, reg[hst_addr].
- hold  in  1  request to stretch SCL before the next data byte.
- wr_strobe  out  1  one-cycle pulse on each register written over I2C.
- wr_idx  out  $clog2(REG_DEPTH)  index of the register written.
- wr_byte  out  8  value written.
- rd_strobe  out  1  one-cycle pulse when a read byte is loaded.
- busy  out  1  high from the matched address ACK until STOP.
- conflict  out  1  one-cycle pulse when a host write is dropped.

Function
REQ-003 SCL and SDA SHALL pass a 2-flop synchroniser, then a filter that changes state only after FILTER_LEN consecutive equal samples; all protocol logic SHALL use the filtered signals.
REQ-004 START or repeated START SHALL be detected as filtered SDA 1->0 while SCL=1; STOP as SDA 0->1 while SCL=1; detection SHALL apply only while the block is not driving SDA.
REQ-005 States SHALL be IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
REQ-006 Any START SHALL enter ADDR from any state and clear the bit counter; any STOP SHALL enter IDLE.
REQ-007 Data bits SHALL be sampled MSB first on the filtered SCL rising edge.
REQ-008 SDA changes SHALL occur 1 clk after the filtered SCL falling edge.
REQ-009 ADDR: after 8 bits, if byte[7:1]==address go to ADDR_ACK and latch rw=byte[0]; otherwise go to IDLE and leave SDA released.
REQ-010 ACK SHALL mean driving SDA low for the full 9th SCL pulse; release occurs 1 clk after its falling edge.
REQ-011 After an ACK with rw=0 the next state SHALL be PTR if no pointer byte has been received since the last START, else WDATA; with rw=1 it SHALL be RDATA.
REQ-012 PTR: a received byte < REG_DEPTH SHALL load the pointer and be ACKed; a byte >= REG_DEPTH SHALL be NACKed (SDA released) and go to IDLE, pointer unchanged.
REQ-013 WDATA: the byte SHALL be written to reg[ptr] at the 8th rising edge, with wr_strobe/wr_idx/wr_byte valid in the same cycle; ptr SHALL increment modulo REG_DEPTH; the byte SHALL be ACKed.
REQ-014 RDATA: reg[ptr] SHALL be loaded into the shift register at the SCL falling edge that ends the ACK, with rd_strobe pulsing; ptr SHALL increment modulo REG_DEPTH.
REQ-015 RDATA_ACK: on master ACK (SDA=0) go to RDATA; on NACK release SDA and go to IDLE.
REQ-016 The pointer SHALL survive repeated START and STOP; only reset clears it.
REQ-017 If an I2C write and a host write target the same index in the same cycle, the I2C write SHALL win and conflict SHALL pulse; host writes to other indices SHALL proceed.
REQ-018 hst_rdata SHALL have 1 clk latency and reflect any write made in the preceding cycle.
REQ-019 With STRETCH_EN=1 and hold=1 sampled at the ACK falling edge, SCL SHALL be driven low until hold=0, then released 1 clk later; with STRETCH_EN=0, hold SHALL be ignored.
REQ-020 When no address is matched, the block SHALL never drive SDA or SCL.

Reset
REQ-021 On reset=0 at a clk edge:
- State SHALL be IDLE; pointer, bit counter and all registers SHALL be 0.
- sda and scl SHALL be Z.
- wr_strobe, rd_strobe, busy and conflict SHALL be 0; hst_rdata, wr_idx and wr_byte SHALL be 0.
- Synchroniser and filter SHALL be set to 1.
REQ-022 Reset asserted mid-transfer SHALL release both lines within 1 clk; after reset the block SHALL ignore the bus until the next START.

Structure
REQ-023 State encodings, the ACK/NACK constants and the filter-length limit SHALL live in the shared I2C header package.
REQ-024 The synchroniser plus glitch filter SHALL be one sub-module, i2c_line_filter, instantiated once for SCL and once for SDA.

Verification
REQ-025 The bench SHALL cover these directed scenarios (address=0x3C, REG_DEPTH=16, FILTER_LEN=3):
- START, 0x78, 0x05, 0xA1, 0xB2, STOP -> ACK on every byte; reg[5]=0xA1, reg[6]=0xB2; two wr_strobe pulses with idx 5, 6.
- START, 0x78, 0x0F, repeated START, 0x79, master ACK, master NACK, STOP -> master reads reg[15] then reg[0] (wrap); ptr=1 after STOP.
- START, 0x78, 0x20 -> NACK on the 0x20 byte, state IDLE, ptr unchanged.
- START, 0x7A -> no ACK; sda and scl never driven during the frame.
- Host writes reg[5]=0x11 while I2C writes reg[5]=0x22 in the same cycle -> reg[5]=0x22, one conflict pulse.
- hold=1 during a read ACK -> SCL held low until hold=0 plus 1 clk; 1-clk SDA glitch -> no false START detected.

Source files
------------

// File: rtl/i2c_slave_regfile_pkg.sv
// Shared I2C definitions: protocol states, ACK/NACK line levels and the
// glitch-filter length limit.
package i2c_slave_regfile_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK
  } state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam int FILTER_LEN_MAX = 15;

endpackage

// File: rtl/i2c_slave_regfile_line_filter.sv
// Two-flop synchroniser followed by a glitch filter that follows the input
// only after FILTER_LEN consecutive samples disagree with the current output.
module i2c_line_filter
  import i2c_slave_regfile_pkg::*;
#(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(FILTER_LEN_MAX + 1);
  localparam logic [CW-1:0] LIM = CW'(FILTER_LEN - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync <= 2'b11;
      cnt  <= '0;
      dout <= 1'b1;
    end else begin
      sync <= {sync[0], din};
      if (sync[1] == dout) begin
        cnt <= '0;
      end else if (cnt == LIM) begin
        dout <= sync[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C slave exposing REG_DEPTH 8-bit registers behind an auto-incrementing
// pointer, with a host port, write/read strobes and optional SCL stretching.
module i2c_slave_regfile
  import i2c_slave_regfile_pkg::*;
#(
  parameter int REG_DEPTH  = 16,
  parameter int FILTER_LEN = 3,
  parameter int STRETCH_EN = 1,
  localparam int IW = $clog2(REG_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  inout  wire           sda,
  inout  wire           scl,
  input  logic [6:0]    address,
  input  logic          hst_we,
  input  logic [IW-1:0] hst_addr,
  input  logic [7:0]    hst_wdata,
  output logic [7:0]    hst_rdata,
  input  logic          hold,
  output logic          wr_strobe,
  output logic [IW-1:0] wr_idx,
  output logic [7:0]    wr_byte,
  output logic          rd_strobe,
  output logic          busy,
  output logic          conflict
);

  localparam logic [8:0] DEPTH9 = 9'(REG_DEPTH);

  logic          scl_f, sda_f, scl_d, sda_d;
  logic          sda_oe, scl_oe;
  state_t        state;
  logic [3:0]    bitcnt;
  logic [7:0]    sr;
  logic [IW-1:0] ptr, ptr_next;
  logic          rw, mack, ptr_rcvd;
  logic [7:0]    regs [REG_DEPTH];
  logic [7:0]    rx_byte, rd_byte;
  logic          scl_rise, scl_fall, start_det, stop_det, i2c_we, stretch_req;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk(clk), .reset(reset), .din(scl), .dout(scl_f));
  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk(clk), .reset(reset), .din(sda), .dout(sda_f));

  assign sda = sda_oe ? 1'b0 : 1'bz;
  assign scl = scl_oe ? 1'b0 : 1'bz;

  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  // Our own SDA drive must never be mistaken for a bus condition.
  assign start_det = scl_f & scl_d & sda_d & ~sda_f & ~sda_oe;
  assign stop_det  = scl_f & scl_d & ~sda_d & sda_f & ~sda_oe;

  assign rx_byte     = {sr[6:0], sda_f};
  assign rd_byte     = regs[ptr];
  assign ptr_next    = (ptr == IW'(REG_DEPTH - 1)) ? '0 : ptr + 1'b1;
  assign i2c_we      = (state == S_WDATA) && scl_rise && (bitcnt == 4'd7);
  assign stretch_req = (STRETCH_EN != 0) && hold;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      bitcnt    <= '0;
      sr        <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      mack      <= NACK;
      ptr_rcvd  <= 1'b0;
      sda_oe    <= 1'b0;
      scl_oe    <= 1'b0;
      busy      <= 1'b0;
      rd_strobe <= 1'b0;
      scl_d     <= 1'b1;
      sda_d     <= 1'b1;
    end else begin
      scl_d     <= scl_f;
      sda_d     <= sda_f;
      rd_strobe <= 1'b0;
      if (scl_oe && !hold) scl_oe <= 1'b0;
      if (start_det) begin
        state    <= S_ADDR;
        bitcnt   <= '0;
        ptr_rcvd <= 1'b0;
        sda_oe   <= 1'b0;
      end else if (stop_det) begin
        state  <= S_IDLE;
        bitcnt <= '0;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        unique case (state)
          S_ADDR, S_PTR, S_WDATA: if (scl_rise) begin
            sr     <= rx_byte;
            bitcnt <= bitcnt + 4'd1;
            if (bitcnt == 4'd7) begin
              bitcnt <= '0;
              if (state == S_ADDR) begin
                if (rx_byte[7:1] == address) begin
                  rw    <= rx_byte[0];
                  state <= S_ADDR_ACK;
                end else begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                end
              end else if (state == S_PTR) begin
                if ({1'b0, rx_byte} < DEPTH9) begin
                  ptr      <= rx_byte[IW-1:0];
                  ptr_rcvd <= 1'b1;
                  state    <= S_PTR_ACK;
                end else begin
                  state <= S_IDLE;
                end
              end else begin
                ptr   <= ptr_next;
                state <= S_WDATA_ACK;
              end
            end
          end
          // First falling edge starts the ACK, the second one ends it.
          S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe <= ACK == 1'b0;
              if (state == S_ADDR_ACK) busy <= 1'b1;
            end else begin
              sda_oe <= 1'b0;
              scl_oe <= stretch_req;
              if (state == S_ADDR_ACK && rw) begin
                sr        <= rd_byte;
                sda_oe    <= ~rd_byte[7];
                rd_strobe <= 1'b1;
                ptr       <= ptr_next;
                state     <= S_RDATA;
              end else if (state == S_ADDR_ACK && !ptr_rcvd) begin
                state <= S_PTR;
              end else begin
                state <= S_WDATA;
              end
            end
          end
          S_RDATA: begin
            if (scl_rise) bitcnt <= bitcnt + 4'd1;
            if (scl_fall) begin
              if (bitcnt == 4'd8) begin
                sda_oe <= 1'b0;
                bitcnt <= '0;
                state  <= S_RDATA_ACK;
              end else begin
                sr     <= {sr[6:0], 1'b0};
                sda_oe <= ~sr[6];
              end
            end
          end
          S_RDATA_ACK: begin
            if (scl_rise) mack <= sda_f;
            if (scl_fall) begin
              if (mack == ACK) begin
                sr        <= rd_byte;
                sda_oe    <= ~rd_byte[7];
                rd_strobe <= 1'b1;
                ptr       <= ptr_next;
                scl_oe    <= stretch_req;
                state     <= S_RDATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= S_IDLE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // The I2C write is applied last so it overrides a same-index host write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
      hst_rdata <= '0;
      wr_strobe <= 1'b0;
      wr_idx    <= '0;
      wr_byte   <= '0;
      conflict  <= 1'b0;
    end else begin
      hst_rdata <= regs[hst_addr];
      wr_strobe <= i2c_we;
      conflict  <= hst_we && i2c_we && (hst_addr == ptr);
      if (hst_we) regs[hst_addr] <= hst_wdata;
      if (i2c_we) begin
        regs[ptr] <= rx_byte;
        wr_idx    <= ptr;
        wr_byte   <= rx_byte;
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench: bit-banged I2C master on a pulled-up bus plus host port
// vectors for the i2c_slave_regfile register file.
module tb_i2c_slave_regfile;

  localparam int T = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  wire        sda, scl;
  logic       m_sda_low = 1'b0, m_scl_low = 1'b0;
  logic [6:0] address = 7'h3C;
  logic       hst_we = 1'b0;
  logic [3:0] hst_addr = '0;
  logic [7:0] hst_wdata = '0;
  logic [7:0] hst_rdata;
  logic       hold = 1'b0;
  logic       wr_strobe, rd_strobe, busy, conflict;
  logic [3:0] wr_idx;
  logic [7:0] wr_byte;

  pullup (sda);
  pullup (scl);
  assign sda = m_sda_low ? 1'b0 : 1'bz;
  assign scl = m_scl_low ? 1'b0 : 1'bz;

  i2c_slave_regfile #(.REG_DEPTH(16), .FILTER_LEN(3), .STRETCH_EN(1)) dut (
    .clk(clk), .reset(reset), .sda(sda), .scl(scl), .address(address),
    .hst_we(hst_we), .hst_addr(hst_addr), .hst_wdata(hst_wdata),
    .hst_rdata(hst_rdata), .hold(hold), .wr_strobe(wr_strobe),
    .wr_idx(wr_idx), .wr_byte(wr_byte), .rd_strobe(rd_strobe),
    .busy(busy), .conflict(conflict));

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  int wr_cnt = 0, rd_cnt = 0, cf_cnt = 0;
  logic [3:0] wr_idx_log [8];
  logic [7:0] wr_byte_log [8];
  bit slave_drove = 1'b0;

  always @(posedge clk) begin
    #2;
    if (wr_strobe === 1'b1) begin
      wr_idx_log[wr_cnt % 8]  = wr_idx;
      wr_byte_log[wr_cnt % 8] = wr_byte;
      wr_cnt++;
    end
    if (rd_strobe === 1'b1) rd_cnt++;
    if (conflict === 1'b1) cf_cnt++;
    if ((sda === 1'b0 && !m_sda_low) || (scl === 1'b0 && !m_scl_low)) slave_drove = 1'b1;
  end

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
    string      name;
  } hvec_t;

  hvec_t hv_init [9];
  hvec_t hv_final [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic half();
    repeat (T) @(negedge clk);
  endtask

  task automatic wait_scl_high();
    int n = 0;
    while (scl !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (scl !== 1'b1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scl_timeout: scl still 0 after 2000 clk, expected 1");
    end
  endtask

  task automatic bus_start();
    m_sda_low = 1'b0; half();
    m_scl_low = 1'b0; wait_scl_high(); half();
    m_sda_low = 1'b1; half();
    m_scl_low = 1'b1; half();
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; half();
    m_scl_low = 1'b0; wait_scl_high(); half();
    m_sda_low = 1'b0; half();
  endtask

  task automatic clock_bit(input logic b, input bit glitch, output logic smp);
    m_sda_low = ~b; half();
    m_scl_low = 1'b0; wait_scl_high();
    if (glitch) begin
      repeat (T / 2) @(negedge clk);
      m_sda_low = ~m_sda_low;
      @(negedge clk);
      m_sda_low = ~m_sda_low;
      repeat (T / 2 - 1) @(negedge clk);
    end else begin
      half();
    end
    smp = sda;
    m_scl_low = 1'b1; half();
  endtask

  task automatic send_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], i == glitch_bit, s);
    clock_bit(1'b1, 1'b0, ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, 1'b0, s);
      d[i] = s;
    end
    clock_bit(mack, 1'b0, s);
  endtask

  task automatic host_op(input hvec_t v);
    @(negedge clk);
    hst_we = v.we; hst_addr = v.addr; hst_wdata = v.wdata;
    @(negedge clk);
    hst_we = 1'b0;
    @(negedge clk);
    check(v.name, hst_rdata, v.exp);
  endtask

  initial begin
    logic       ack, s;
    logic [7:0] d;

    hv_init[0] = '{1'b1, 4'd1,  8'h5A, 8'h5A, "hw_reg1"};
    hv_init[1] = '{1'b1, 4'd15, 8'hF0, 8'hF0, "hw_reg15"};
    hv_init[2] = '{1'b1, 4'd0,  8'h0A, 8'h0A, "hw_reg0"};
    hv_init[3] = '{1'b1, 4'd3,  8'h33, 8'h33, "hw_reg3"};
    hv_init[4] = '{1'b0, 4'd1,  8'h00, 8'h5A, "hr_reg1"};
    hv_init[5] = '{1'b0, 4'd15, 8'h00, 8'hF0, "hr_reg15"};
    hv_init[6] = '{1'b0, 4'd0,  8'h00, 8'h0A, "hr_reg0"};
    hv_init[7] = '{1'b0, 4'd3,  8'h00, 8'h33, "hr_reg3"};
    hv_init[8] = '{1'b0, 4'd5,  8'h00, 8'h00, "hr_reg5_init"};

    hv_final[0] = '{1'b0, 4'd5,  8'h00, 8'h22, "final_reg5"};
    hv_final[1] = '{1'b0, 4'd6,  8'h00, 8'hB2, "final_reg6"};
    hv_final[2] = '{1'b0, 4'd7,  8'h00, 8'hC3, "final_reg7"};
    hv_final[3] = '{1'b0, 4'd15, 8'h00, 8'hF0, "final_reg15"};
    hv_final[4] = '{1'b0, 4'd0,  8'h00, 8'h0A, "final_reg0"};
    hv_final[5] = '{1'b0, 4'd1,  8'h00, 8'h5A, "final_reg1"};
    hv_final[6] = '{1'b1, 4'd9,  8'h99, 8'h99, "final_hw_reg9"};
    hv_final[7] = '{1'b0, 4'd3,  8'h00, 8'h33, "final_reg3"};

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_hst_rdata", hst_rdata, 8'h00);
    check("rst_wr_strobe", wr_strobe, 1'b0);
    check("rst_rd_strobe", rd_strobe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_conflict", conflict, 1'b0);
    check("rst_wr_idx", wr_idx, 4'd0);
    check("rst_wr_byte", wr_byte, 8'h00);
    check("rst_sda", sda, 1'b1);
    check("rst_scl", scl, 1'b1);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 9; i++) host_op(hv_init[i]);

    // Write two bytes from pointer 5
    wr_cnt = 0;
    bus_start();
    send_byte(8'h78, -1, ack); check("s1_ack_addr", ack, 1'b0);
    check("s1_busy", busy, 1'b1);
    send_byte(8'h05, -1, ack); check("s1_ack_ptr", ack, 1'b0);
    send_byte(8'hA1, -1, ack); check("s1_ack_d0", ack, 1'b0);
    send_byte(8'hB2, -1, ack); check("s1_ack_d1", ack, 1'b0);
    bus_stop();
    check("s1_busy_after_stop", busy, 1'b0);
    check("s1_wr_cnt", wr_cnt, 2);
    check("s1_wr_idx0", wr_idx_log[0], 4'd5);
    check("s1_wr_byte0", wr_byte_log[0], 8'hA1);
    check("s1_wr_idx1", wr_idx_log[1], 4'd6);
    check("s1_wr_byte1", wr_byte_log[1], 8'hB2);

    // Pointer 15, repeated START, read with wrap
    rd_cnt = 0;
    bus_start();
    send_byte(8'h78, -1, ack); check("s2_ack_addr_w", ack, 1'b0);
    send_byte(8'h0F, -1, ack); check("s2_ack_ptr", ack, 1'b0);
    bus_start();
    send_byte(8'h79, -1, ack); check("s2_ack_addr_r", ack, 1'b0);
    recv_byte(1'b0, d); check("s2_rd_reg15", d, 8'hF0);
    recv_byte(1'b1, d); check("s2_rd_reg0", d, 8'h0A);
    bus_stop();
    check("s2_rd_cnt", rd_cnt, 2);

    // Out-of-range pointer is NACKed and the block drops to idle
    bus_start();
    send_byte(8'h78, -1, ack); check("s3_ack_addr", ack, 1'b0);
    send_byte(8'h20, -1, ack); check("s3_nack_ptr", ack, 1'b1);
    send_byte(8'h05, -1, ack); check("s3_idle_nack", ack, 1'b1);
    bus_stop();
    bus_start();
    send_byte(8'h79, -1, ack); check("s3_ack_addr_r", ack, 1'b0);
    recv_byte(1'b1, d); check("s3_ptr_kept_reg1", d, 8'h5A);
    bus_stop();

    // Foreign address: lines never driven
    slave_drove = 1'b0;
    bus_start();
    send_byte(8'h7A, -1, ack); check("s4_nack_addr", ack, 1'b1);
    send_byte(8'h00, -1, ack); check("s4_nack_data", ack, 1'b1);
    bus_stop();
    check("s4_never_driven", slave_drove, 1'b0);

    // Host and I2C write reg[5] in the same cycle
    wr_cnt = 0; cf_cnt = 0;
    bus_start();
    send_byte(8'h78, -1, ack); check("s5_ack_addr", ack, 1'b0);
    send_byte(8'h05, -1, ack); check("s5_ack_ptr", ack, 1'b0);
    for (int i = 7; i >= 1; i--) clock_bit(8'h22 >> i, 1'b0, s);
    m_sda_low = 1'b1; half();
    m_scl_low = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    hst_we = 1'b1; hst_addr = 4'd5; hst_wdata = 8'h11;
    @(negedge clk);
    hst_we = 1'b0;
    wait_scl_high(); half();
    m_scl_low = 1'b1; half();
    clock_bit(1'b1, 1'b0, ack); check("s5_ack_data", ack, 1'b0);
    bus_stop();
    check("s5_conflict_cnt", cf_cnt, 1);
    check("s5_wr_cnt", wr_cnt, 1);

    // Clock stretching on the address ACK of a read (pointer now 6)
    hold = 1'b1;
    bus_start();
    send_byte(8'h79, -1, ack); check("s6_ack_addr", ack, 1'b0);
    m_scl_low = 1'b0;
    repeat (30) @(negedge clk);
    check("s6_scl_held", scl, 1'b0);
    hold = 1'b0;
    #1 check("s6_scl_held_1clk", scl, 1'b0);
    @(negedge clk);
    check("s6_scl_released", scl, 1'b1);
    recv_byte(1'b1, d); check("s6_rd_reg6", d, 8'hB2);
    bus_stop();

    // 1-clk SDA glitch while SCL is high must not look like a START
    wr_cnt = 0;
    bus_start();
    send_byte(8'h78, -1, ack); check("s7_ack_addr", ack, 1'b0);
    send_byte(8'h07, -1, ack); check("s7_ack_ptr", ack, 1'b0);
    send_byte(8'hC3, 7, ack);  check("s7_ack_data", ack, 1'b0);
    bus_stop();
    check("s7_wr_cnt", wr_cnt, 1);
    check("s7_wr_idx", wr_idx_log[0], 4'd7);
    check("s7_wr_byte", wr_byte_log[0], 8'hC3);

    for (int i = 0; i < 8; i++) host_op(hv_final[i]);

    // Reset while the slave drives its ACK
    bus_start();
    for (int i = 7; i >= 0; i--) clock_bit(8'h78 >> i, 1'b0, s);
    m_sda_low = 1'b0; half();
    check("s8_ack_driven", sda, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("s8_rst_sda_released", sda, 1'b1);
    check("s8_rst_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    bus_stop();
    m_scl_low = 1'b1; half();
    send_byte(8'h78, -1, ack); check("s8_no_start_ignored", ack, 1'b1);
    bus_stop();
    host_op('{1'b0, 4'd5, 8'h00, 8'h00, "s8_reg5_cleared"});
    host_op('{1'b0, 4'd15, 8'h00, 8'h00, "s8_reg15_cleared"});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
